pmem_burst_responder: RTL and testbench
=======================================

Name: pmem_burst_responder

Overview:
Synthesizable responder for the physical-memory burst interface that the mp4 core drives on pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_rdata and pmem_resp. The block services 256-bit cache-line transfers as four 64-bit beats from an internal line-organised array, with a programmable access latency. It replaces the behavioural memory model in bring-up and FPGA builds. It also flags protocol violations by the initiator.

Parameters:
DEPTH_LINES, 256, number of 32-byte lines held; power of two, minimum 2.
LATENCY, 4, cycles from request acceptance to the first resp beat; minimum 1.
BEATS, 4, beats per line; fixed at 4, and the data width is 64.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
pmem_read  input  1  line read request, held until the burst completes
pmem_write  input  1  line write request, held until the burst completes
pmem_address  input  32  byte address of the line; bits [4:0] ignored
pmem_wdata  input  64  write beat, sampled on cycles where pmem_resp=1
pmem_rdata  output  64  read beat, valid on cycles where pmem_resp=1
pmem_resp  output  1  beat strobe, 4 consecutive cycles per transfer
range_err  output  1  sticky flag: address beyond DEPTH_LINES
proto_err  output  1  sticky flag: read and write both high, or request dropped mid-transfer

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE; pmem_resp=0, pmem_rdata=0, range_err=0, proto_err=0, beat and latency counters=0.
  - Array contents are not reset.
  - Reset mid-burst abandons the transfer. Beats already written remain in the array.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE:
  - On a rising edge with pmem_read|pmem_write=1, latch the op and line index = pmem_address[5 +: log2(DEPTH_LINES)].
  - Range check: pmem_address >= DEPTH_LINES*32 sets in_range=0 and sets range_err.
  - If both read and write are high, set proto_err and service the request as a read.
  - Load the latency counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle. At 0, go to BURST with beat=0.
  - With LATENCY=1, WAIT lasts one cycle.
  - Timing: request sampled at edge k gives the first pmem_resp=1 in cycle k+LATENCY.
- BURST:
  - pmem_resp=1 for exactly 4 consecutive cycles, beat 0..3.
  - Read: pmem_rdata = line[beat*64 +: 64], beat 0 = lowest bytes. Data is registered so it is valid in the same cycle as resp. Out-of-range reads return 0.
  - Write: line[beat*64 +: 64] <= pmem_wdata at the edge ending each resp cycle. Out-of-range writes are dropped.
  - After beat 3, go to DONE.
- DONE:
  - pmem_resp=0.
  - Wait until pmem_read=0 and pmem_write=0, then go to IDLE.
  - A new request is accepted no earlier than the cycle after the requests drop, so back-to-back transfers have a minimum gap of 1 idle cycle.
- Dropped request: if pmem_read|pmem_write falls to 0 during WAIT or BURST, set proto_err, deassert resp next cycle, and go to IDLE. Completed write beats remain.
- Error flags: range_err and proto_err clear only on rst.
- Address and op stability: pmem_address and the op are latched at acceptance. Changes during the transfer are ignored.
- Beat counter: 2 bits; terminal count 3 only.

Test Plan:
- Write then read: write line 0x00000040 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444…, drop the request, then read the same line.
  - Required: 4 resp cycles, beats returned in order.
  - Required: first resp exactly LATENCY=4 cycles after acceptance, then 1 gap cycle.
- Ignored low bits: read 0x0000005C.
  - Required: same line as 0x00000040.
- Out of range: with DEPTH_LINES=256, write to 0x00002000, then read it back.
  - Required: range_err=1, 4 resp beats each time, rdata=0.
  - Required: line 0 is unchanged.
- Simultaneous read and write: assert both on line 1.
  - Required: proto_err=1, read data returned, array unchanged.
- Reset mid-burst: assert rst during beat 2 of a write to line 2.
  - Required: resp=0 immediately.
  - Required: a subsequent read returns new beats 0–1 and old beats 2–3.
- Dropped request: deassert pmem_read during WAIT.
  - Required: proto_err=1, no resp pulse, FSM back in IDLE.
  - Required: the next read completes normally.

Source files
------------

// File: rtl/pmem_burst_responder_if.sv
// pmem_burst_responder_if
//   Bundles the physical-memory burst bus between the mp4 core and the
//   line-organised responder.
//   master : core side  - drives read/write/address/wdata, sees rdata/resp
//   slave  : memory side - sees read/write/address/wdata, drives rdata/resp
interface pmem_burst_responder_if;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder
//   Services 256-bit cache-line transfers as four 64-bit beats out of an
//   internal line array, with a fixed programmable access latency.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        pmem bus (slave side): read/write/address/wdata in,
//                rdata/resp out
//     range_err  sticky: a request addressed beyond DEPTH_LINES lines
//     proto_err  sticky: read+write together, or request dropped mid-transfer
module pmem_burst_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4,
    parameter int BEATS       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pmem_burst_responder_if.slave bus,
    output logic                  range_err,
    output logic                  proto_err
);
    localparam int AW = $clog2(DEPTH_LINES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    // Array holds one 64-bit word per beat; word index = {line, beat}.
    logic [63:0]   r_mem [DEPTH_LINES*BEATS];

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_beat;
    logic [AW-1:0] r_line;
    logic          r_wr;
    logic          r_in_range;
    logic          r_resp;
    logic [63:0]   r_rdata;
    logic          r_range_err;
    logic          r_proto_err;

    logic          w_req;
    logic          w_in_range;
    logic [AW-1:0] w_line;
    logic [1:0]    w_nbeat;
    logic          w_rd_ok;
    logic          w_wr_en;

    assign w_req      = bus.pmem_read | bus.pmem_write;
    // Anything at or above DEPTH_LINES*32 bytes has a nonzero upper part.
    assign w_in_range = (bus.pmem_address >> (5 + AW)) == 32'd0;
    assign w_line     = bus.pmem_address[5 +: AW];
    assign w_nbeat    = r_beat + 2'd1;
    assign w_rd_ok    = r_in_range & ~r_wr;
    // A write beat lands at the edge closing its resp cycle, unless the
    // initiator has already dropped the request.
    assign w_wr_en    = (r_state == BURST) & r_wr & r_in_range & w_req;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[{r_line, r_beat}] <= bus.pmem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_line      <= '0;
            r_wr        <= 1'b0;
            r_in_range  <= 1'b0;
            r_resp      <= 1'b0;
            r_rdata     <= '0;
            r_range_err <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp  <= 1'b0;
                    r_rdata <= '0;
                    if (w_req) begin
                        // Read wins when both are asserted.
                        r_wr       <= bus.pmem_write & ~bus.pmem_read;
                        r_line     <= w_line;
                        r_in_range <= w_in_range;
                        if (!w_in_range)
                            r_range_err <= 1'b1;
                        if (bus.pmem_read && bus.pmem_write)
                            r_proto_err <= 1'b1;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        r_proto_err <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_beat  <= 2'd0;
                        r_resp  <= 1'b1;
                        r_rdata <= w_rd_ok ? r_mem[{r_line, 2'd0}] : 64'd0;
                        r_state <= BURST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BURST: begin
                    if (!w_req) begin
                        r_proto_err <= 1'b1;
                        r_resp      <= 1'b0;
                        r_rdata     <= '0;
                        r_state     <= IDLE;
                    end else if (r_beat == 2'(BEATS - 1)) begin
                        r_resp  <= 1'b0;
                        r_rdata <= '0;
                        r_state <= DONE;
                    end else begin
                        // Fetch the next beat so it is valid alongside resp.
                        r_beat  <= w_nbeat;
                        r_rdata <= w_rd_ok ? r_mem[{r_line, w_nbeat}] : 64'd0;
                    end
                end
                DONE: begin
                    if (!w_req)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_resp  = r_resp;
    assign bus.pmem_rdata = r_rdata;
    assign range_err      = r_range_err;
    assign proto_err      = r_proto_err;
endmodule

// File: tb/tb_pmem_burst_responder.sv
module tb_pmem_burst_responder;
    localparam int DEPTH_LINES = 256;
    localparam int LATENCY     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic range_err, proto_err;

    pmem_burst_responder_if bus ();

    pmem_burst_responder #(
        .DEPTH_LINES(DEPTH_LINES),
        .LATENCY(LATENCY),
        .BEATS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .range_err(range_err),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [63:0] mdl [int];   // reference array, key = line*4 + beat
    logic [63:0] exp_q [$];   // scoreboard of expected read beats

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One full transfer. Write beat b carries base*(b+1).
    // abort_beat in 0..3 asserts rst during that beat's resp cycle.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [63:0] base, input int abort_beat);
        int          line;
        bit          inr;
        bit          eff_wr;
        int          lat;
        logic [63:0] e;
        logic [63:0] wd;
        line   = int'(addr[12:5]);
        inr    = addr < DEPTH_LINES * 32;
        eff_wr = wr && !rd;
        if (rd)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(inr ? mdl[line*4 + b] : 64'd0);

        @(negedge clk);
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        @(posedge clk);   // acceptance edge
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.pmem_resp && lat < 20);
        chk("latency", 64'(lat), 64'(LATENCY));
        if (!bus.pmem_resp) begin
            if (rd) for (int b = 0; b < 4; b++) void'(exp_q.pop_front());
            bus.pmem_read = 0; bus.pmem_write = 0;
            return;
        end

        for (int b = 0; b < 4; b++) begin
            chk("resp_beat", 64'(bus.pmem_resp), 64'd1);
            if (rd) begin
                if (exp_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rdata", bus.pmem_rdata, e);
                end
            end
            if (eff_wr) begin
                wd = base * 64'(b + 1);
                bus.pmem_wdata = wd;
            end
            if (b == abort_beat) begin
                rst = 1'b1;
                #1;
                chk("rst_resp", 64'(bus.pmem_resp), 64'd0);
                rst = 1'b0;
                bus.pmem_read = 0; bus.pmem_write = 0;
                return;
            end
            if (eff_wr && inr) mdl[line*4 + b] = wd;
            @(posedge clk); #1;
        end
        chk("resp_done", 64'(bus.pmem_resp), 64'd0);
        bus.pmem_read  = 0;
        bus.pmem_write = 0;
        @(posedge clk);   // DONE -> IDLE
    endtask

    initial begin
        int seen;
        bus.pmem_read = 0; bus.pmem_write = 0;
        bus.pmem_address = '0; bus.pmem_wdata = '0;
        #23;
        chk("rst_resp", 64'(bus.pmem_resp), 64'd0);
        chk("rst_rdata", bus.pmem_rdata, 64'd0);
        chk("rst_range", 64'(range_err), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        rst = 1'b0;

        // Known contents for lines 0 and 1.
        xfer(1'b0, 1'b1, 32'h0000_0000, 64'h0101_0101_0101_0101, -1);
        xfer(1'b0, 1'b1, 32'h0000_0020, 64'h0F0F_0F0F_0F0F_0F0F, -1);

        // Write then read line 0x40; low address bits ignored.
        xfer(1'b0, 1'b1, 32'h0000_0040, 64'h1111_1111_1111_1111, -1);
        xfer(1'b1, 1'b0, 32'h0000_0040, 64'd0, -1);
        xfer(1'b1, 1'b0, 32'h0000_005C, 64'd0, -1);
        chk("range_before", 64'(range_err), 64'd0);

        // Out of range write and read; line 0 must not be aliased.
        xfer(1'b0, 1'b1, 32'h0000_2000, 64'h7777_7777_7777_7777, -1);
        chk("range_set", 64'(range_err), 64'd1);
        xfer(1'b1, 1'b0, 32'h0000_2000, 64'd0, -1);
        xfer(1'b1, 1'b0, 32'h0000_0000, 64'd0, -1);

        // Read and write together on line 1: serviced as read.
        chk("proto_before", 64'(proto_err), 64'd0);
        bus.pmem_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        xfer(1'b1, 1'b1, 32'h0000_0020, 64'd0, -1);
        chk("proto_both", 64'(proto_err), 64'd1);
        xfer(1'b1, 1'b0, 32'h0000_0020, 64'd0, -1);

        // Reset during beat 2 of a write to line 2.
        xfer(1'b0, 1'b1, 32'h0000_0040, 64'h9999_9999_9999_9999, 2);
        chk("rst_range_clr", 64'(range_err), 64'd0);
        chk("rst_proto_clr", 64'(proto_err), 64'd0);
        xfer(1'b1, 1'b0, 32'h0000_0040, 64'd0, -1);

        // Request dropped during WAIT.
        @(negedge clk);
        bus.pmem_read = 1'b1; bus.pmem_address = 32'h0000_0040;
        @(posedge clk);
        @(posedge clk); #1;
        bus.pmem_read = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.pmem_resp) seen++;
        end
        chk("drop_noresp", 64'(seen), 64'd0);
        chk("drop_proto", 64'(proto_err), 64'd1);
        xfer(1'b1, 1'b0, 32'h0000_0040, 64'd0, -1);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
